// File: rtl/vec_mem_sequencer.sv
// Memory-stage sequencer: scalar pass-through, LANES-wide vector serialization, host port sharing.
// The host port and its fairness logic exist only when VMS_HOST_PORT_EN is defined.
module vec_mem_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd_i,
  input  logic              core_we_i,
  input  logic              core_vec_rd_i,
  input  logic              core_vec_we_i,
  input  logic [DATA_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic [DATA_W-1:0] core_vec_addr_i  [LANES],
  input  logic [DATA_W-1:0] core_vec_wdata_i [LANES],
  output logic [DATA_W-1:0] core_rdata_o,
  output logic [DATA_W-1:0] core_vec_rdata_o [LANES],
  output logic              stall_o,
`ifdef VMS_HOST_PORT_EN
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [DATA_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic [DATA_W-1:0] host_rdata_o,
`endif
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StVec, StVdone} state_e;

  state_e            state_q;
  logic [LaneW-1:0]  lane_q;
  logic [DATA_W-1:0] vreg_q [LANES];

  logic             vec_req, sc_req, host_win, vec_issue;
  logic [LaneW-1:0] issue_lane;

  // Requests are masked while reset is low so every output falls to its idle value at once.
  assign vec_req = (core_vec_rd_i | core_vec_we_i) & reset;
  assign sc_req  = (core_rd_i | core_we_i) & reset & ~vec_req;

`ifdef VMS_HOST_PORT_EN
  logic host_pri_q, host_req;
  assign host_req = host_req_i & reset;
  assign host_win = (state_q == StIdle) && host_req && (host_pri_q || !(vec_req || sc_req));
`else
  assign host_win = 1'b0;
`endif

  assign vec_issue  = reset && ((state_q == StIdle && vec_req && !host_win) || state_q == StVec);
  assign issue_lane = (state_q == StVec) ? lane_q : '0;

  assign core_vec_rdata_o = vreg_q;

  always_comb begin
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = 1'b0;
    core_rdata_o = '0;
    stall_o      = 1'b0;
`ifdef VMS_HOST_PORT_EN
    host_gnt_o   = 1'b0;
    host_rdata_o = '0;
    if (host_win) begin
      mem_addr_o   = host_addr_i;
      mem_wdata_o  = host_wdata_i;
      mem_we_o     = host_we_i;
      host_gnt_o   = 1'b1;
      host_rdata_o = mem_rdata_i;
      stall_o      = vec_req | sc_req;
    end else
`endif
    if (vec_issue) begin
      mem_addr_o  = core_vec_addr_i[issue_lane];
      mem_wdata_o = core_vec_wdata_i[issue_lane];
      mem_we_o    = core_vec_we_i;
      stall_o     = 1'b1;
    end else if (state_q == StIdle && sc_req) begin
      mem_addr_o   = core_addr_i;
      mem_wdata_o  = core_wdata_i;
      mem_we_o     = core_we_i;
      core_rdata_o = mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lane_q  <= '0;
      for (int i = 0; i < LANES; i++) vreg_q[i] <= '0;
`ifdef VMS_HOST_PORT_EN
      host_pri_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (vec_issue) begin
            lane_q  <= LaneW'(1);
            state_q <= StVec;
          end
        end
        StVec: begin
          if (lane_q == LaneW'(LANES - 1)) begin
            lane_q  <= '0;
            state_q <= StVdone;
          end else begin
            lane_q <= lane_q + LaneW'(1);
          end
        end
        StVdone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      // A vector with the write flag low is a load; each lane lands at the edge ending its cycle.
      if (vec_issue && !core_vec_we_i) vreg_q[issue_lane] <= mem_rdata_i;
`ifdef VMS_HOST_PORT_EN
      if (host_gnt_o) host_pri_q <= 1'b0;
      else if (host_req) host_pri_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: transaction-level reference model with per-cycle
// comparison, directed cases from the test plan and randomized scalar/vector traffic.
module tb_vec_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_rd_i, core_we_i, core_vec_rd_i, core_vec_we_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [31:0] core_vec_addr_i [4];
  logic [31:0] core_vec_wdata_i [4];
  logic [31:0] core_rdata_o;
  logic [31:0] core_vec_rdata_o [4];
  logic        stall_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_we_o;
`ifdef VMS_HOST_PORT_EN
  logic        host_req_i, host_we_i, host_gnt_o;
  logic [31:0] host_addr_i, host_wdata_i, host_rdata_o;
  logic        exp_gnt;
  logic [31:0] exp_hrdata;
`endif

  always #5 clk = ~clk;

  vec_mem_sequencer #(.DATA_W(32), .LANES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .core_rd_i        (core_rd_i),
    .core_we_i        (core_we_i),
    .core_vec_rd_i    (core_vec_rd_i),
    .core_vec_we_i    (core_vec_we_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_vec_addr_i  (core_vec_addr_i),
    .core_vec_wdata_i (core_vec_wdata_i),
    .core_rdata_o     (core_rdata_o),
    .core_vec_rdata_o (core_vec_rdata_o),
    .stall_o          (stall_o),
`ifdef VMS_HOST_PORT_EN
    .host_req_i       (host_req_i),
    .host_we_i        (host_we_i),
    .host_addr_i      (host_addr_i),
    .host_wdata_i     (host_wdata_i),
    .host_gnt_o       (host_gnt_o),
    .host_rdata_o     (host_rdata_o),
`endif
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_we_o         (mem_we_o),
    .mem_rdata_i      (mem_rdata_i)
  );

  // Single-port memory the DUT talks to: combinational read, write at the clock edge.
  logic [31:0] mem [1024];
  assign mem_rdata_i = mem[mem_addr_o[11:2]];
  always @(posedge clk) if (mem_we_o) mem[mem_addr_o[11:2]] <= mem_wdata_o;

  // Reference model state.
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_vreg [4];
  logic        exp_valid, exp_stall, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic        vpend;
  int          vpend_idx;
  logic [31:0] vpend_val;
  logic [31:0] tva [4];
  logic [31:0] tvd [4];

  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall", 32'(stall_o), 32'(exp_stall));
      chk("mem_we", 32'(mem_we_o), 32'(exp_we));
      chk("mem_addr", mem_addr_o, exp_addr);
      chk("mem_wdata", mem_wdata_o, exp_wdata);
      chk("core_rdata", core_rdata_o, exp_rdata);
      for (int i = 0; i < 4; i++) chk("vec_rdata", core_vec_rdata_o[i], exp_vreg[i]);
`ifdef VMS_HOST_PORT_EN
      chk("host_gnt", 32'(host_gnt_o), 32'(exp_gnt));
      chk("host_rdata", host_rdata_o, exp_hrdata);
`endif
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (vpend) begin
      exp_vreg[vpend_idx] = vpend_val;
      vpend = 1'b0;
    end
    exp_stall = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rdata = '0;
`ifdef VMS_HOST_PORT_EN
    exp_gnt    = 1'b0;
    exp_hrdata = '0;
`endif
    core_rd_i = 1'b0; core_we_i = 1'b0; core_vec_rd_i = 1'b0; core_vec_we_i = 1'b0;
  endtask

  task automatic drive_idle();
    begin_cycle();
    core_addr_i  = $urandom;
    core_wdata_i = $urandom;
  endtask

  task automatic do_scalar(input bit we, input logic [31:0] a, input logic [31:0] d);
    begin_cycle();
    core_rd_i = !we; core_we_i = we; core_addr_i = a; core_wdata_i = d;
    exp_addr = a; exp_wdata = d; exp_we = we; exp_rdata = ref_mem[widx(a)];
    if (we) ref_mem[widx(a)] = d;
  endtask

  // Four lane cycles with stall, then one VDONE cycle; a scalar request alongside is ignored.
  task automatic do_vec(input bit we, input bit junk, input int host_from);
    logic [31:0] ja;
    ja = $urandom_range(0, 255) << 2;
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      core_vec_rd_i = !we; core_vec_we_i = we;
      core_vec_addr_i = tva; core_vec_wdata_i = tvd;
      core_rd_i = junk; core_addr_i = ja; core_wdata_i = 32'h5A5A_0000;
`ifdef VMS_HOST_PORT_EN
      if (i == host_from) begin
        host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h40; host_wdata_i = 32'h0;
      end
`endif
      if (i < 4) begin
        exp_stall = 1'b1; exp_addr = tva[i]; exp_wdata = tvd[i]; exp_we = we;
        if (we) ref_mem[widx(tva[i])] = tvd[i];
        else begin
          vpend = 1'b1; vpend_idx = i; vpend_val = ref_mem[widx(tva[i])];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; exp_valid = 1'b0; vpend = 1'b0; vpend_idx = 0; vpend_val = '0;
    exp_stall = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    core_rd_i = 1'b0; core_we_i = 1'b0; core_vec_rd_i = 1'b0; core_vec_we_i = 1'b0;
    core_addr_i = '0; core_wdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      core_vec_addr_i[i] = '0; core_vec_wdata_i[i] = '0; exp_vreg[i] = '0;
    end
`ifdef VMS_HOST_PORT_EN
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    exp_gnt = 1'b0; exp_hrdata = '0;
`endif
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0; ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_vreg0", core_vec_rdata_o[0], 32'd0);
    exp_valid = 1'b1;

    // Scalar store then load.
    do_scalar(1'b1, 32'h40, 32'hDEAD_BEEF);
    do_scalar(1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("lit_scalar_load", core_rdata_o, 32'hDEAD_BEEF);

    // Vector store then vector load of the same four words.
    for (int i = 0; i < 4; i++) begin
      tva[i] = 32'h100 + 32'(4 * i); tvd[i] = 32'(i + 1);
    end
    do_vec(1'b1, 1'b0, 9);
    do_vec(1'b0, 1'b1, 9);
    @(negedge clk);
    chk("lit_vdone_stall", 32'(stall_o), 32'd0);
    for (int i = 0; i < 4; i++) chk("lit_vec_load", core_vec_rdata_o[i], 32'(i + 1));
    drive_idle();

`ifdef VMS_HOST_PORT_EN
    // Contention with host_pri clear: core first, then host wins while the core stalls.
    begin_cycle();
    core_rd_i = 1'b1; core_addr_i = 32'h40; core_wdata_i = 32'h0;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 32'h104; host_wdata_i = 32'h55;
    exp_addr = 32'h40; exp_rdata = ref_mem[widx(32'h40)];
    begin_cycle();
    core_rd_i = 1'b1; core_addr_i = 32'h108;
    exp_addr = 32'h104; exp_wdata = 32'h55; exp_gnt = 1'b1; exp_stall = 1'b1;
    exp_hrdata = ref_mem[widx(32'h104)];
    @(negedge clk);
    chk("lit_host_rdata", host_rdata_o, 32'd2);
    begin_cycle();
    host_req_i = 1'b0;
    core_rd_i = 1'b1; core_addr_i = 32'h108;
    exp_addr = 32'h108; exp_rdata = ref_mem[widx(32'h108)];

    // Host request raised during lane 1 of a vector load waits until the first IDLE cycle.
    do_vec(1'b0, 1'b0, 1);
    begin_cycle();
    host_we_i = 1'b1; host_addr_i = 32'h40; host_wdata_i = 32'h1234_5678;
    exp_addr = 32'h40; exp_wdata = 32'h1234_5678; exp_we = 1'b1; exp_gnt = 1'b1;
    exp_hrdata = ref_mem[widx(32'h40)];
    ref_mem[widx(32'h40)] = 32'h1234_5678;
    begin_cycle();
    host_req_i = 1'b0; host_we_i = 1'b0;
    do_scalar(1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("lit_host_write", core_rdata_o, 32'h1234_5678);
`endif

    // Randomized traffic over a 256-word window so addresses alias often.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      if (kind == 3 || kind == 4) begin
        for (int i = 0; i < 4; i++) begin
          tva[i] = $urandom_range(0, 255) << 2; tvd[i] = $urandom;
        end
        do_vec(kind == 4, 1'($urandom_range(0, 1)), 9);
      end else if (kind == 0) begin
        drive_idle();
      end else begin
        do_scalar(kind == 2, $urandom_range(0, 255) << 2, $urandom);
      end
    end

    // Reset during lane 2 of a vector store to an untouched region.
    for (int i = 0; i < 4; i++) begin
      tva[i] = 32'h800 + 32'(4 * i); tvd[i] = 32'(11 + i);
    end
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      core_vec_we_i = 1'b1; core_vec_addr_i = tva; core_vec_wdata_i = tvd;
      exp_stall = 1'b1; exp_addr = tva[i]; exp_wdata = tvd[i]; exp_we = 1'b1;
      if (i < 2) ref_mem[widx(tva[i])] = tvd[i];
    end
    exp_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_we_o), 32'd0);
    chk("rst_mid_stall", 32'(stall_o), 32'd0);
    for (int i = 0; i < 4; i++) chk("rst_mid_vreg", core_vec_rdata_o[i], 32'd0);
    core_vec_we_i = 1'b0;
    for (int i = 0; i < 4; i++) exp_vreg[i] = '0;
    vpend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_idle();
    exp_valid = 1'b1;
    chk("rst_lane0_mem", mem[widx(32'h800)], 32'd11);
    chk("rst_lane1_mem", mem[widx(32'h804)], 32'd12);
    chk("rst_lane2_mem", mem[widx(32'h808)], 32'd0);
    chk("rst_lane3_mem", mem[widx(32'h80C)], 32'd0);
    do_scalar(1'b0, 32'h804, 32'h0);
    repeat (3) drive_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
